// File: rtl/dcm_prog_if.sv
// dcm_prog_if: command/status handshake plus the DCM dynamic-programming pins.
// The master side issues commands and models the DCM; the slave side is dcm_prog.
interface dcm_prog_if;
  logic       start;
  logic [7:0] mul_m1;
  logic [7:0] div_m1;
  logic       busy;
  logic       done;
  logic       err;
  logic       progen;
  logic       progdata;
  logic       progdone;
  logic       locked;

  modport master (
    output start, mul_m1, div_m1, progdone, locked,
    input  busy, done, err, progen, progdata
  );

  modport slave (
    input  start, mul_m1, div_m1, progdone, locked,
    output busy, done, err, progen, progdata
  );
endinterface

// File: rtl/dcm_prog.sv
// dcm_prog: shifts a LoadD / LoadM / GO command into a DCM's PROGEN/PROGDATA port,
// then waits for the PROGDONE handshake and LOCKED, with a cycle-count timeout.
module dcm_prog #(
  parameter int unsigned TIMEOUT = 65535
) (
  input logic       clk,
  input logic       rst_n,
  dcm_prog_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    LOADD     = 4'd1,
    GAP1      = 4'd2,
    LOADM     = 4'd3,
    GAP2      = 4'd4,
    GO        = 4'd5,
    WAIT_LO   = 4'd6,
    WAIT_HI   = 4'd7,
    WAIT_LOCK = 4'd8
  } state_t;

  // Counter value seen in the last allowed wait cycle; err fires on the edge after it.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 32'd1);

  state_t      state_q;
  logic [7:0]  mul_q;
  logic [8:0]  shift_q;
  logic [3:0]  cnt_q;
  logic [15:0] tmo_q;
  logic        pd_meta_q;
  logic        pd_sync_q;
  logic        lk_meta_q;
  logic        lk_sync_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        progen_q;
  logic        progdata_q;
  logic        adv_s;

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.progen   = progen_q;
  assign bus.progdata = progdata_q;

  // Two-flop synchronizers for the DCM status inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pd_meta_q <= 1'b0;
      pd_sync_q <= 1'b0;
      lk_meta_q <= 1'b0;
      lk_sync_q <= 1'b0;
    end else begin
      pd_meta_q <= bus.progdone;
      pd_sync_q <= pd_meta_q;
      lk_meta_q <= bus.locked;
      lk_sync_q <= lk_meta_q;
    end
  end

  // Exit condition of whichever wait state is active.
  always_comb begin
    adv_s = 1'b0;
    case (state_q)
      WAIT_LO:   adv_s = ~pd_sync_q;
      WAIT_HI:   adv_s = pd_sync_q;
      WAIT_LOCK: adv_s = lk_sync_q;
      default:   adv_s = 1'b0;
    endcase
  end

  // Sequencer; outputs are registered so each reflects the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mul_q      <= 8'd0;
      shift_q    <= 9'd0;
      cnt_q      <= 4'd0;
      tmo_q      <= 16'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      progen_q   <= 1'b0;
      progdata_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          progen_q   <= 1'b0;
          progdata_q <= 1'b0;
          if (bus.start) begin
            if (bus.mul_m1 == 8'd0) begin
              err_q <= 1'b1;
            end else begin
              // First LoadD bit goes out immediately; the rest wait in shift_q, LSB first.
              mul_q      <= bus.mul_m1;
              shift_q    <= {bus.div_m1, 1'b0};
              cnt_q      <= 4'd9;
              busy_q     <= 1'b1;
              progen_q   <= 1'b1;
              progdata_q <= 1'b1;
              state_q    <= LOADD;
            end
          end
        end
        LOADD, LOADM: begin
          if (cnt_q != 4'd0) begin
            progdata_q <= shift_q[0];
            shift_q    <= {1'b0, shift_q[8:1]};
            cnt_q      <= cnt_q - 4'd1;
          end else begin
            progen_q   <= 1'b0;
            progdata_q <= 1'b0;
            state_q    <= (state_q == LOADD) ? GAP1 : GAP2;
          end
        end
        GAP1: begin
          shift_q    <= {mul_q, 1'b1};
          cnt_q      <= 4'd9;
          progen_q   <= 1'b1;
          progdata_q <= 1'b1;
          state_q    <= LOADM;
        end
        GAP2: begin
          progen_q   <= 1'b1;
          progdata_q <= 1'b0;
          state_q    <= GO;
        end
        GO: begin
          progen_q   <= 1'b0;
          progdata_q <= 1'b0;
          tmo_q      <= 16'd0;
          state_q    <= WAIT_LO;
        end
        WAIT_LO, WAIT_HI, WAIT_LOCK: begin
          progen_q   <= 1'b0;
          progdata_q <= 1'b0;
          // An advance in the final allowed cycle takes priority over the timeout.
          if (adv_s) begin
            tmo_q <= tmo_q + 16'd1;
            case (state_q)
              WAIT_LO: state_q <= WAIT_HI;
              WAIT_HI: state_q <= WAIT_LOCK;
              default: begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end
            endcase
          end else if (tmo_q == TMO_LAST) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        default: begin
          busy_q     <= 1'b0;
          progen_q   <= 1'b0;
          progdata_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dcm_prog.md
DCM_PROG -- requirements
Module: dcm_prog

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 65535, giving the max clk cycles to wait for progdone high or locked high before flagging an error.
REQ-002 The block SHALL have port clk  input  1  program clock, also driven to DCM PROGCLK externally; all logic on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port start  input  1  one-cycle request to reprogram; sampled only in IDLE.
REQ-005 The block SHALL have port mul_m1  input  8  multiplier minus one (M-1); legal 1..255.
REQ-006 The block SHALL have port div_m1  input  8  divider minus one (D-1); legal 0..255.
REQ-007 The block SHALL have port busy  output  1  high from accepted start until done or err pulse.
REQ-008 The block SHALL have port done  output  1  one-cycle pulse: reprogram complete and DCM locked.
REQ-009 The block SHALL have port err  output  1  one-cycle pulse: illegal mul_m1 or timeout.
REQ-010 The block SHALL have port progen  output  1  to DCM PROGEN.
REQ-011 The block SHALL have port progdata  output  1  to DCM PROGDATA.
REQ-012 The block SHALL have port progdone  input  1  from DCM PROGDONE.
REQ-013 The block SHALL have port locked  input  1  from DCM LOCKED.

Function
REQ-014 progdone and locked SHALL each pass through a 2-flop synchronizer; all decisions SHALL use the synchronized versions.
REQ-015 States SHALL be IDLE, LOADD, GAP1, LOADM, GAP2, GO, WAIT_LO, WAIT_HI, WAIT_LOCK.
REQ-016 In IDLE, start with mul_m1==0 SHALL pulse err the next cycle and remain in IDLE with busy low and progen never asserted.
REQ-017 In IDLE, start with mul_m1!=0 SHALL latch mul_m1/div_m1, set busy and enter LOADD on the next edge; later changes on mul_m1/div_m1 SHALL be ignored.
REQ-018 LOADD SHALL last exactly 10 cycles with progen=1; progdata SHALL be 1, 0, then div_m1[0] through div_m1[7] (LSB first).
REQ-019 GAP1 and GAP2 SHALL last exactly 1 cycle each with progen=0, progdata=0.
REQ-020 LOADM SHALL last exactly 10 cycles with progen=1; progdata SHALL be 1, 1, then mul_m1[0] through mul_m1[7].
REQ-021 GO SHALL last exactly 1 cycle with progen=1, progdata=0.
REQ-022 In every state other than LOADD, LOADM and GO, progen and progdata SHALL be 0.
REQ-023 WAIT_LO SHALL advance to WAIT_HI when synchronized progdone==0.
REQ-024 WAIT_HI SHALL advance to WAIT_LOCK when synchronized progdone==1.
REQ-025 WAIT_LOCK SHALL, when synchronized locked==1, pulse done for one cycle, clear busy and return to IDLE in the same transition.
REQ-026 A 16-bit timeout counter SHALL clear on entry to WAIT_LO and increment each cycle through WAIT_LO, WAIT_HI and WAIT_LOCK.
REQ-027 When the timeout counter reaches TIMEOUT, the block SHALL pulse err, clear busy and return to IDLE.
REQ-028 If the timeout limit and the advance condition coincide, the advance SHALL win.
REQ-029 start asserted while busy SHALL be ignored, without queuing.
REQ-030 done and err SHALL never be high in the same cycle.
REQ-031 The command-to-done latency SHALL be 23 cycles of programming plus wait-state time.

Reset
REQ-032 Asserting rst_n low at any time, including mid-shift, SHALL immediately force the FSM to IDLE.
REQ-033 During reset, busy, done, err, progen and progdata SHALL be 0, and the shift register, timeout counter and synchronizers SHALL be 0.
REQ-034 After rst_n rises, the block SHALL accept start on the first edge it is sampled.
REQ-035 A reset during LOADD or LOADM leaves the DCM with a partial command; the next start SHALL resend the full sequence.

Verification
REQ-036 start, mul_m1=0x04, div_m1=0x01 -> progen high 10 cycles with progdata 1,0,1,0,0,0,0,0,0,0; low 1 cycle; high 10 cycles with 1,1,0,0,1,0,0,0,0,0; low 1; high 1 with progdata 0.
REQ-037 In the REQ-036 run, progdone model drops 3 cycles after GO, rises 20 cycles later and locked follows 5 cycles later -> exactly one done pulse 2 cycles after synchronized locked is seen, busy falls with it, and no err pulse.
REQ-038 start with mul_m1=0x00 -> err pulse, busy stays 0, progen stays 0.
REQ-039 TIMEOUT=100, progdone held high forever -> err pulse 100 cycles after entering WAIT_LO, then IDLE.
REQ-040 rst_n low in LOADM bit 5, then released, then a new start -> full 23-cycle sequence restarts from LoadD bit 0.
REQ-041 start pulsed repeatedly while busy -> exactly one programming sequence and one done.
